// File: rtl/bin2seg_display.sv
// Binary to multi-digit seven-segment display driver.
// A sequential double-dabble engine converts an unsigned value to BCD.
// The result drives a static per-digit segment bus plus a time-multiplexed
// single-digit bus, with optional leading-zero blanking and overflow dashes.
module bin2seg_display #(
  parameter int IN_W           = 7,
  parameter int DIGITS         = 2,
  parameter int SCAN_DIV       = 1000,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       bin,
  input  logic                  blank_lz,
  output logic                  done,
  output logic                  ovf,
  output logic [7*DIGITS-1:0]   seg_flat,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg_mux
);

  // Enough BCD nibbles that the engine can never truncate, even when
  // fewer digits are displayed.
  localparam int NB   = (IN_W + 2) / 3 + 1;
  localparam int SRW  = 4 * NB + IN_W;
  localparam int MAXN = (NB > DIGITS) ? NB : DIGITS;
  localparam int CW   = $clog2(IN_W + 1);
  localparam int SCW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // XOR mask that converts an active-high pattern to the output polarity.
  localparam logic [6:0] POL      = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
  localparam logic [6:0] SEG_DASH = 7'b1000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   load;
  logic                   shift_en;
  logic                   upd;
  logic [CW-1:0]          bitcnt;
  logic [SRW-1:0]         sr;
  logic                   blz_q;

  logic [4*MAXN-1:0]      bcdw;
  logic [7*DIGITS-1:0]    flat_c;
  logic                   ovf_c;
  logic                   seen;
  logic [3:0]             dig;
  logic [6:0]             pat;

  logic [SCW-1:0]         sc_cnt;
  logic                   sc_wrap;
  logic [DIGITS-1:0]      an_nxt;
  logic [6:0]             mux_nxt;

  // Active-high segment pattern (g..a) for a decimal digit; non-decimal codes blank.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
  function automatic logic [SRW-1:0] dd_step(input logic [SRW-1:0] v);
    logic [SRW-1:0] r;
    r = v;
    for (int i = 0; i < NB; i++) begin
      if (r[IN_W+4*i +: 4] >= 4'd5)
        r[IN_W+4*i +: 4] = r[IN_W+4*i +: 4] + 4'd3;
    end
    return {r[SRW-2:0], 1'b0};
  endfunction

  // Conversion FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Conversion FSM next state and control strobes.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    load      = 1'b0;
    shift_en  = 1'b0;
    upd       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (bitcnt == CW'(IN_W - 1)) state_nxt = UPDATE;
      end
      UPDATE: begin
        upd       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register and captured blanking flag; pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (load) begin
      sr    <= {{(4*NB){1'b0}}, bin};
      blz_q <= blank_lz;
    end else if (shift_en) begin
      sr    <= dd_step(sr);
    end
  end

  // Bit counter, done strobe and registered display result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitcnt   <= '0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      seg_flat <= {DIGITS{POL}};
    end else begin
      if (load)          bitcnt <= '0;
      else if (shift_en) bitcnt <= bitcnt + CW'(1);
      done <= upd;
      if (upd) begin
        seg_flat <= flat_c;
        ovf      <= ovf_c;
      end
    end
  end

  // Decode the finished BCD into overflow flag and per-digit patterns.
  always_comb begin
    bcdw              = '0;
    bcdw[4*NB-1:0]    = sr[SRW-1:IN_W];
    ovf_c             = 1'b0;
    seen              = 1'b0;
    dig               = 4'd0;
    pat               = 7'd0;
    flat_c            = '0;
    for (int i = DIGITS; i < NB; i++) begin
      if (bcdw[4*i +: 4] != 4'd0) ovf_c = 1'b1;
    end
    // Walk from the most significant digit so "seen" marks the first nonzero.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      dig = bcdw[4*i +: 4];
      if (dig != 4'd0) seen = 1'b1;
      if (ovf_c)
        pat = SEG_DASH;
      else if (blz_q && !seen && (i != 0))
        pat = 7'd0;
      else
        pat = seg_encode(dig);
      flat_c[7*i +: 7] = pat ^ POL;
    end
  end

  // Next digit enable and the segment slice it selects.
  always_comb begin
    sc_wrap = (sc_cnt == SCW'(SCAN_DIV - 1));
    an_nxt  = an;
    if (sc_wrap) an_nxt = (an << 1) | (an >> (DIGITS - 1));
    mux_nxt = POL;
    for (int i = 0; i < DIGITS; i++) begin
      if (an_nxt[i]) mux_nxt = seg_flat[7*i +: 7];
    end
  end

  // Free-running scan: divider, rotating digit enable, registered mux output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc_cnt  <= '0;
      an      <= DIGITS'(1);
      seg_mux <= POL;
    end else begin
      sc_cnt  <= sc_wrap ? '0 : sc_cnt + SCW'(1);
      an      <= an_nxt;
      seg_mux <= mux_nxt;
    end
  end

endmodule

// File: tb/tb_bin2seg_display.sv
// Bench for bin2seg_display: active-high and active-low instances side by side,
// checked every cycle against a decimal-arithmetic model plus literal vectors.
module tb_bin2seg_display;

  localparam int IN_W     = 7;
  localparam int DIGITS   = 2;
  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic blank_lz = 1'b0;
  logic [IN_W-1:0] bin = '0;

  logic rdy_h, done_h, ovf_h;
  logic [7*DIGITS-1:0] flat_h;
  logic [DIGITS-1:0] an_h;
  logic [6:0] mux_h;

  logic rdy_l, done_l, ovf_l;
  logic [7*DIGITS-1:0] flat_l;
  logic [DIGITS-1:0] an_l;
  logic [6:0] mux_l;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  bin2seg_display #(.IN_W(IN_W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(0)) u_dut_h (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_h), .bin(bin),
    .blank_lz(blank_lz), .done(done_h), .ovf(ovf_h), .seg_flat(flat_h),
    .an(an_h), .seg_mux(mux_h));

  bin2seg_display #(.IN_W(IN_W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1)) u_dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_l), .bin(bin),
    .blank_lz(blank_lz), .done(done_l), .ovf(ovf_l), .seg_flat(flat_l),
    .an(an_l), .seg_mux(mux_l));

  always #5 clk = ~clk;

  logic [6:0] seg_tab [0:9] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  function automatic int pow10(input int n);
    int p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  // What digit i must show for value v, from the display rules.
  function automatic logic [6:0] digit_pat(input int v, input bit blz, input int i);
    if (v >= pow10(DIGITS)) return 7'b1000000;
    if (blz && (i > 0) && (v < pow10(i))) return 7'b0000000;
    return seg_tab[(v / pow10(i)) % 10];
  endfunction

  function automatic logic [7*DIGITS-1:0] exp_flat(input int v, input bit blz);
    logic [7*DIGITS-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[7*i +: 7] = digit_pat(v, blz, i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: busy countdown, decimal result, scan index.
  int   m_cnt = 0, m_val = 0, m_scan = 0, m_idx = 0;
  bit   m_ready = 1'b1, m_done = 1'b0, m_ovf = 1'b0, m_blz = 1'b0;
  logic [7*DIGITS-1:0] m_flat = '0;
  logic [6:0] m_mux = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready <= 1'b1; m_done <= 1'b0; m_ovf <= 1'b0; m_flat <= '0; m_mux <= '0;
      m_scan <= 0; m_idx <= 0; m_cnt <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_ready) begin
        if (in_valid) begin
          m_ready <= 1'b0; m_cnt <= IN_W; m_val <= int'(bin); m_blz <= blank_lz;
        end
      end else if (m_cnt == 0) begin
        m_flat  <= exp_flat(m_val, m_blz);
        m_ovf   <= (m_val >= pow10(DIGITS));
        m_done  <= 1'b1;
        m_ready <= 1'b1;
      end else begin
        m_cnt <= m_cnt - 1;
      end
      if (m_scan == SCAN_DIV - 1) begin
        m_scan <= 0;
        m_idx  <= (m_idx + 1) % DIGITS;
        m_mux  <= m_flat[7*((m_idx + 1) % DIGITS) +: 7];
      end else begin
        m_scan <= m_scan + 1;
        m_mux  <= m_flat[7*m_idx +: 7];
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", rdy_h, m_ready);
      chk("done", done_h, m_done);
      chk("ovf", ovf_h, m_ovf);
      chk("seg_flat", flat_h, m_flat);
      chk("an", an_h, 1 << m_idx);
      chk("seg_mux", mux_h, m_mux);
      chk("in_ready_al", rdy_l, m_ready);
      chk("done_al", done_l, m_done);
      chk("ovf_al", ovf_l, m_ovf);
      chk("seg_flat_al", flat_l, m_flat ^ 14'h3fff);
      chk("an_al", an_l, 1 << m_idx);
      chk("seg_mux_al", mux_l, m_mux ^ 7'h7f);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic convert(input int v, input bit blz, input string tag);
    int k;
    in_valid = 1'b1; bin = IN_W'(v); blank_lz = blz;
    tick();
    in_valid = 1'b0;
    k = 0;
    do begin tick(); k++; end while (!done_h && k < 30);
    chk({tag, "_latency"}, k, IN_W + 1);
  endtask

  initial begin
    int k, n, changes, run;
    logic [DIGITS-1:0] prev;

    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_ready", rdy_h, 1);
    chk("rst_done", done_h, 0);
    chk("rst_ovf", ovf_h, 0);
    chk("rst_flat", flat_h, 14'h0000);
    chk("rst_an", an_h, 2'b01);
    chk("rst_mux", mux_h, 7'b0000000);
    chk("rst_flat_al", flat_l, 14'h3fff);
    chk("rst_mux_al", mux_l, 7'h7f);
    rst = 1'b0;
    tick();

    convert(81, 1'b0, "c81");
    chk("c81_flat", flat_h, 14'b1111111_0000110);
    chk("c81_ovf", ovf_h, 0);
    chk("c81_ready", rdy_h, 1);
    chk("c81_flat_al", flat_l, 14'b0000000_1111001);

    convert(0, 1'b0, "z0");
    chk("z0_flat", flat_h, 14'b0111111_0111111);
    convert(0, 1'b1, "z1");
    chk("z1_flat", flat_h, 14'b0000000_0111111);
    convert(5, 1'b1, "f1");
    chk("f1_flat", flat_h, 14'b0000000_1101101);

    convert(100, 1'b0, "o100");
    chk("o100_ovf", ovf_h, 1);
    chk("o100_flat", flat_h, 14'b1000000_1000000);
    convert(127, 1'b1, "o127");
    chk("o127_ovf", ovf_h, 1);
    chk("o127_flat", flat_h, 14'b1000000_1000000);
    convert(99, 1'b0, "n99");
    chk("n99_ovf", ovf_h, 0);
    chk("n99_flat", flat_h, 14'b1101111_1101111);

    // in_valid held high; bin changes right after acceptance.
    in_valid = 1'b1; bin = 7'd12; blank_lz = 1'b0;
    tick();
    bin = 7'd34;
    k = 0;
    do begin tick(); k++; end while (!done_h && k < 30);
    chk("hold_latency", k, IN_W + 1);
    chk("hold_flat12", flat_h, 14'b0000110_1011011);
    k = 0;
    do begin tick(); k++; end while (!done_h && k < 30);
    chk("hold_gap", k, IN_W + 2);
    in_valid = 1'b0;
    chk("hold_flat34", flat_h, 14'b1001111_1100110);

    // Asynchronous reset in the middle of a conversion.
    in_valid = 1'b1; bin = 7'd81;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_flat", flat_h, 14'h0000);
    chk("arst_flat_al", flat_l, 14'h3fff);
    chk("arst_ready", rdy_h, 1);
    chk("arst_done", done_h, 0);
    chk("arst_an", an_h, 2'b01);
    chk("arst_mux", mux_h, 7'b0000000);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    repeat (12) begin tick(); if (done_h) n++; end
    chk("arst_no_done", n, 0);
    chk("arst_ready_after", rdy_h, 1);
    chk("arst_flat_after", flat_h, 14'h0000);

    // Scan of result 42.
    convert(42, 1'b0, "s42");
    chk("s42_flat", flat_h, 14'b1100110_1011011);
    prev = an_h; changes = 0; k = 0; run = 0;
    while (changes < 3 && k < 40) begin
      tick(); k++; run++;
      if (an_h == 2'b01) begin
        chk("scan_mux_d0", mux_h, 7'b1011011);
        chk("scan_mux_d0_al", mux_l, 7'b0100100);
      end else begin
        chk("scan_mux_d1", mux_h, 7'b1100110);
        chk("scan_mux_d1_al", mux_l, 7'b0011001);
      end
      if (an_h != prev) begin
        if (changes > 0) chk("scan_period", run, SCAN_DIV);
        changes++;
        run = 0;
        prev = an_h;
      end
    end
    chk("scan_changes", changes, 3);

    repeat (2) tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
